fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin burst arbiter sharing the write port of one FIFO between
//   N_REQ producers. One owner at a time writes up to BURST_LEN words, the
//   FIFO full flag gates every write combinationally, and priority rotates
//   to the requester after the owner once a tenure ends.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   req        per-requester valid
//   req_data   packed request words, slot i at [i*DW +: DW]
//   gnt        one-hot grant (combinational); req[i] && gnt[i] consumes a word
//   fifo_full  FIFO full flag
//   fifo_we    FIFO write enable (combinational)
//   fifo_din   FIFO write data, 0 when nothing is granted
//   busy       registered, 1 while in BURST
//   owner      registered index of the current/last owner
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no tenure; grant the first requester from rr_ptr, word 1 moves
// S_BURST | owner holds the port until BURST_LEN words, release, or reset

module fifo_wr_arbiter #(
   parameter int N_REQ     = 4,
   parameter int DW        = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    gnt,
   input  logic                fifo_full,
   output logic                fifo_we,
   output logic [DW-1:0]       fifo_din,
   output logic                busy,
   output logic [2:0]          owner
);

   localparam int            PW          = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [PW:0]   N_REQ_W     = (PW+1)'(N_REQ);
   localparam logic [3:0]    BURST_LEN_W = 4'(BURST_LEN);

   typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [3:0]    beat_cnt_q, beat_cnt_d;
   logic          busy_q, busy_d;
   logic          pick_vld;
   logic [PW-1:0] pick_idx;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] idx);
      logic [PW:0] t;
      t = {1'b0, idx} + (PW+1)'(1);
      if (t >= N_REQ_W) t = '0;
      return t[PW-1:0];
   endfunction

   // First asserted request searching upward from rr_ptr, wrapping mod N_REQ.
   always_comb begin
      logic [PW:0] cand;
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + (PW+1)'(k);
         if (cand >= N_REQ_W) cand = cand - N_REQ_W;
         if (!pick_vld && req[cand[PW-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         beat_cnt_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_full && pick_vld) begin
               owner_d = pick_idx;
               if (BURST_LEN == 1) begin
                  rr_ptr_d = wrap_inc(pick_idx);
               end else begin
                  state_d    = S_BURST;
                  beat_cnt_d = 4'd1;
               end
            end
         end
         S_BURST: begin
            // A dropped request releases the tenure even while the FIFO is full.
            if (!req[owner_q]) begin
               state_d  = S_IDLE;
               rr_ptr_d = wrap_inc(owner_q);
            end else if (!fifo_full) begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               if (beat_cnt_d == BURST_LEN_W) begin
                  state_d  = S_IDLE;
                  rr_ptr_d = wrap_inc(owner_q);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_BURST);
   end

   // Grant is held off for the whole reset cycle so nothing is written then.
   always_comb begin
      gnt = '0;
      if (rst) begin
         if (state_q == S_IDLE) begin
            if (!fifo_full && pick_vld) gnt[pick_idx] = 1'b1;
         end else begin
            gnt[owner_q] = req[owner_q] && !fifo_full;
         end
      end
      fifo_din = '0;
      for (int i = 0; i < N_REQ; i++) begin
         fifo_din = fifo_din | (req_data[i*DW +: DW] & {DW{gnt[i]}});
      end
      fifo_we = |(req & gnt);
   end

   assign busy  = busy_q;
   assign owner = 3'(owner_q);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        fifo_full;
   logic        fifo_we;
   logic [7:0]  fifo_din;
   logic        busy;
   logic [2:0]  owner;

   fifo_wr_arbiter #(.N_REQ(4), .DW(8), .BURST_LEN(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_din(fifo_din),
      .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_count = 0;

   typedef struct packed {
      logic [1:0] src;
      logic [7:0] data;
      logic       busy;
   } exp_t;
   exp_t expq[$];

   // producer model
   logic [7:0] src_mem[4][32];
   int         head[4];
   int         tail[4];
   logic [3:0] en;
   logic [3:0] cons;

   // simple 16x8 FIFO model, write side only
   logic       use_fifo = 1'b0;
   logic       full_man = 1'b0;
   logic [7:0] fmem[16];
   int         fcount = 0;
   logic [7:0] exp_data[16];

   assign fifo_full = use_fifo ? (fcount >= 16) : full_man;

   always @(posedge clk) begin
      if (use_fifo && fifo_we && fcount < 16) begin
         fmem[fcount[3:0]] <= fifo_din;
         fcount <= fcount + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void upd();
      for (int i = 0; i < 4; i++) begin
         req[i] = en[i] && (head[i] != tail[i]);
         req_data[i*8 +: 8] = (head[i] != tail[i]) ? src_mem[i][head[i]] : 8'h00;
      end
   endfunction

   task automatic load(input int i, input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         src_mem[i][tail[i]] = base + 8'(k);
         tail[i]++;
      end
   endtask

   task automatic expect_burst(input int s, input logic [7:0] base, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         e.src  = 2'(s);
         e.data = base + 8'(k);
         e.busy = (k != 0);
         expq.push_back(e);
      end
   endtask

   task automatic wait_writes(input int target, input int budget);
      int n = 0;
      while (wr_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("wait_writes_timeout", (wr_count >= target), 1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (expq.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("drain_pending", expq.size(), 0);
      repeat (3) @(posedge clk);
   endtask

   // driver: pops words the DUT consumed in the cycle just ended
   initial begin
      forever begin
         @(negedge clk);
         cons = req & gnt;
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) if (cons[i]) head[i]++;
         upd();
      end
   end

   // monitor / scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         check("inv_onehot", $onehot0(gnt), 1);
         check("inv_gnt_req", gnt & ~req, 0);
         check("inv_we_full", fifo_we && fifo_full, 0);
         check("inv_we_gnt", fifo_we, |gnt);
         if (fifo_we) begin
            wr_count++;
            if (expq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_write: got din %0h gnt %0b expected no write", fifo_din, gnt);
            end else begin
               e = expq.pop_front();
               check("wr_data", fifo_din, e.data);
               check("wr_gnt", gnt, 4'b0001 << e.src);
               check("wr_busy", busy, e.busy);
               if (e.busy) check("wr_owner", owner, {1'b0, e.src});
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int ord[4];
      int base;
      int idx;
      ord[0] = 1; ord[1] = 2; ord[2] = 3; ord[3] = 0;
      rst = 1'b0;
      en  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end

      // reset with all requesters active, then saturation round-robin
      load(0, 8'h00, 8);
      load(1, 8'h10, 4);
      load(2, 8'h20, 4);
      load(3, 8'h30, 4);
      upd();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         @(negedge clk);
         check("rst_gnt", gnt, 0);
         check("rst_we", fifo_we, 0);
         check("rst_din", fifo_din, 0);
         check("rst_busy", busy, 0);
         check("rst_owner", owner, 0);
      end
      expect_burst(0, 8'h00, 4);
      expect_burst(1, 8'h10, 4);
      expect_burst(2, 8'h20, 4);
      expect_burst(3, 8'h30, 4);
      expect_burst(0, 8'h04, 4);
      @(posedge clk);
      #2 rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("sat_consecutive_we", fifo_we, 1);
      end
      drain(50);

      // single requester, longer than one burst
      @(posedge clk);
      #2;
      load(2, 8'hA0, 6);
      upd();
      expect_burst(2, 8'hA0, 4);
      expect_burst(2, 8'hA4, 2);
      drain(50);
      @(negedge clk);
      check("single_busy_end", busy, 0);
      check("single_owner_end", owner, 2);

      // full stall mid-burst, then rotation to requester 2
      @(posedge clk);
      #2;
      base = wr_count;
      load(1, 8'hB0, 6);
      load(2, 8'hC0, 2);
      upd();
      expect_burst(1, 8'hB0, 4);
      expect_burst(2, 8'hC0, 2);
      expect_burst(1, 8'hB4, 2);
      wait_writes(base + 2, 40);
      #2 full_man = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_gnt", gnt, 0);
         check("stall_we", fifo_we, 0);
         check("stall_busy", busy, 1);
      end
      @(posedge clk);
      #2 full_man = 1'b0;
      drain(50);

      // early release by requester 3, pointer wraps to 0
      @(posedge clk);
      #2;
      base = wr_count;
      load(3, 8'hD0, 5);
      load(0, 8'hE0, 2);
      upd();
      expect_burst(3, 8'hD0, 1);
      expect_burst(0, 8'hE0, 2);
      wait_writes(base + 1, 40);
      #2;
      en[3] = 1'b0;
      upd();
      @(negedge clk);
      check("release_idle_gnt", gnt, 0);
      @(negedge clk);
      check("post_release_gnt", gnt, 4'b0001);
      drain(50);
      head[3] = tail[3];
      en[3]   = 1'b1;
      upd();

      // integration with the FIFO model: fills to exactly 16
      @(posedge clk);
      #2;
      use_fifo = 1'b1;
      base = wr_count;
      load(0, 8'h40, 8);
      load(1, 8'h50, 8);
      load(2, 8'h60, 8);
      load(3, 8'h70, 8);
      upd();
      for (int j = 0; j < 4; j++) begin
         expect_burst(ord[j], 8'(8'h40 + 8'(ord[j] * 16)), 4);
         for (int k = 0; k < 4; k++) begin
            idx = j * 4 + k;
            exp_data[idx] = 8'(8'h40 + 8'(ord[j] * 16) + 8'(k));
         end
      end
      wait_writes(base + 16, 80);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("fifo_count", fcount, 16);
      check("fifo_full_gnt", gnt, 0);
      check("fifo_full_busy", busy, 0);
      check("fifo_writes", wr_count - base, 16);
      for (int k = 0; k < 16; k++) check("fifo_readback", fmem[k], exp_data[k]);
      check("final_pending", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
